// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode, issue-state and decode definitions shared by the issue stage
//
// Purpose : opcode enum, controller state enum, decoded-operand struct and the
//           decode function used by lc3b_issue_ctrl.
// Ports   : none (package).
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'h0,
        op_add  = 4'h1,
        op_ldb  = 4'h2,
        op_stb  = 4'h3,
        op_jsr  = 4'h4,
        op_and  = 4'h5,
        op_ldr  = 4'h6,
        op_str  = 4'h7,
        op_rti  = 4'h8,
        op_xor  = 4'h9,
        op_ldi  = 4'ha,
        op_sti  = 4'hb,
        op_jmp  = 4'hc,
        op_shf  = 4'hd,
        op_lea  = 4'he,
        op_trap = 4'hf
    } opcode_t;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_BR = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic       src1_en;
        logic [2:0] src1;
        logic       src2_en;
        logic [2:0] src2;
        logic       cc_rd;
        logic       dst_en;
        logic [2:0] dst;
        logic       cc_wr;
        logic       is_ctrl;
    } decode_t;

    function automatic decode_t decode(input logic [15:0] instr);
        decode_t d;
        d         = '0;
        d.src1    = instr[8:6];
        d.dst     = instr[11:9];
        d.src2    = instr[2:0];
        case (opcode_t'(instr[15:12]))
            op_add, op_and, op_xor: begin
                d.src1_en = 1'b1;
                d.src2_en = ~instr[5];
                d.dst_en  = 1'b1;
                d.cc_wr   = 1'b1;
            end
            op_ldr, op_ldb, op_ldi, op_shf: begin
                d.src1_en = 1'b1;
                d.dst_en  = 1'b1;
                d.cc_wr   = 1'b1;
            end
            op_str, op_stb, op_sti: begin
                d.src1_en = 1'b1;
                d.src2_en = 1'b1;
                d.src2    = instr[11:9];
            end
            op_lea: begin
                d.dst_en  = 1'b1;
            end
            op_br: begin
                d.cc_rd   = (instr[11:9] != 3'b000);
                d.is_ctrl = 1'b1;
            end
            op_jmp: begin
                d.src1_en = 1'b1;
                d.is_ctrl = 1'b1;
            end
            op_jsr: begin
                // bit 11 clear is JSRR, which reads its base register
                d.src1_en = ~instr[11];
                d.dst_en  = 1'b1;
                d.dst     = 3'd7;
                d.is_ctrl = 1'b1;
            end
            op_trap: begin
                d.dst_en  = 1'b1;
                d.dst     = 3'd7;
                d.is_ctrl = 1'b1;
            end
            op_rti: begin
                d.is_ctrl = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lc3b_scoreboard.sv
// rtl/lc3b_scoreboard.sv - in-flight write counters for R0-R7 and the condition codes
//
// Purpose : counts outstanding writes per register and for CC; answers busy/full
//           queries for the indexes presented by the issue controller.
// Ports   : clk, rst_n (sync active-low); inc_*_i issue-side increments;
//           dec_*_i writeback-side decrements; q_*_idx_i query indexes;
//           *_busy_o (counter != 0), *_full_o (counter == MAX_INFLIGHT).
module lc3b_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_en_i,
    input  logic [2:0] inc_idx_i,
    input  logic       inc_cc_i,
    input  logic       dec_en_i,
    input  logic [2:0] dec_idx_i,
    input  logic       dec_cc_i,
    input  logic [2:0] q_src1_idx_i,
    input  logic [2:0] q_src2_idx_i,
    input  logic [2:0] q_dst_idx_i,
    output logic       src1_busy_o,
    output logic       src2_busy_o,
    output logic       dst_full_o,
    output logic       cc_busy_o,
    output logic       cc_full_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [CW-1:0] reg_cnt_q [8];
    logic [CW-1:0] reg_cnt_d [8];
    logic [CW-1:0] cc_cnt_q;
    logic [CW-1:0] cc_cnt_d;

    // Issue and retire on the same counter cancel; a retire against an
    // empty counter is dropped so the count never wraps below zero.
    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c,
                                               input logic inc,
                                               input logic dec);
        if (inc && !dec)
            return c + 1'b1;
        else if (dec && !inc && c != '0)
            return c - 1'b1;
        else
            return c;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            reg_cnt_d[i] = next_cnt(reg_cnt_q[i],
                                    inc_en_i && (inc_idx_i == 3'(i)),
                                    dec_en_i && (dec_idx_i == 3'(i)));
        end
        cc_cnt_d = next_cnt(cc_cnt_q, inc_cc_i, dec_cc_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) reg_cnt_q[i] <= '0;
            cc_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) reg_cnt_q[i] <= reg_cnt_d[i];
            cc_cnt_q <= cc_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (dec_en_i && !(inc_en_i && inc_idx_i == dec_idx_i))
                assert (reg_cnt_q[dec_idx_i] != '0);
            if (dec_cc_i && !inc_cc_i)
                assert (cc_cnt_q != '0);
        end
    end

    assign src1_busy_o = (reg_cnt_q[q_src1_idx_i] != '0);
    assign src2_busy_o = (reg_cnt_q[q_src2_idx_i] != '0);
    assign dst_full_o  = (reg_cnt_q[q_dst_idx_i] >= CNT_MAX);
    assign cc_busy_o   = (cc_cnt_q != '0);
    assign cc_full_o   = (cc_cnt_q >= CNT_MAX);

endmodule

// File: rtl/lc3b_issue_ctrl.sv
// rtl/lc3b_issue_ctrl.sv - LC-3b issue stage: one-entry hold, scoreboard check, branch serialisation
//
// Purpose : holds one fetched instruction and releases it when its sources,
//           CC and destination capacity are clear; blocks issue after a
//           control-flow op until br_resolve. Macro LC3B_ISSUE_STALL_CNT_EN
//           adds a stall cycle counter (stall_cnt) with a clear (stall_clr).
// Ports   : clk, rst_n; fetch side if_valid/if_ready/if_instr/if_pc;
//           issue side id_valid/id_ready/id_instr/id_pc; writeback
//           wb_valid/wb_dest/wb_cc; branch resolve br_resolve/br_taken.
module lc3b_issue_ctrl
    import lc3b_types::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    input  logic        wb_valid,
    input  logic [2:0]  wb_dest,
    input  logic        wb_cc,
    input  logic        br_resolve,
`ifdef LC3B_ISSUE_STALL_CNT_EN
    input  logic        br_taken,
    input  logic        stall_clr,
    output logic [31:0] stall_cnt
`else
    input  logic        br_taken
`endif
);

    ctrl_state_t state_q, state_d;
    logic        held_q, held_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;

    decode_t dec;
    logic    src1_busy, src2_busy, dst_full, cc_busy, cc_full;
    logic    issue_fire, flush, accept;

    assign dec = decode(instr_q);

    lc3b_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_en_i     (issue_fire && dec.dst_en),
        .inc_idx_i    (dec.dst),
        .inc_cc_i     (issue_fire && dec.cc_wr),
        .dec_en_i     (wb_valid),
        .dec_idx_i    (wb_dest),
        .dec_cc_i     (wb_valid && wb_cc),
        .q_src1_idx_i (dec.src1),
        .q_src2_idx_i (dec.src2),
        .q_dst_idx_i  (dec.dst),
        .src1_busy_o  (src1_busy),
        .src2_busy_o  (src2_busy),
        .dst_full_o   (dst_full),
        .cc_busy_o    (cc_busy),
        .cc_full_o    (cc_full)
    );

    assign id_valid = held_q && (state_q == RUN)
                   && !(dec.src1_en && src1_busy)
                   && !(dec.src2_en && src2_busy)
                   && !(dec.cc_rd   && cc_busy)
                   && !(dec.dst_en  && dst_full)
                   && !(dec.cc_wr   && cc_full);

    assign issue_fire = id_valid && id_ready;
    // A taken resolve kills the held word, so the slot is free that same
    // cycle: fetch has already redirected and its new word must land.
    assign flush      = (state_q == WAIT_BR) && br_resolve && br_taken;
    assign if_ready   = !held_q || issue_fire || flush;
    assign accept     = if_valid && if_ready;

    assign id_instr = instr_q;
    assign id_pc    = pc_q;

    always_comb begin
        held_d  = held_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        state_d = state_q;

        if (accept) begin
            held_d  = 1'b1;
            instr_d = if_instr;
            pc_d    = if_pc;
        end else if (issue_fire || flush) begin
            held_d  = 1'b0;
        end

        case (state_q)
            RUN:     if (issue_fire && dec.is_ctrl) state_d = WAIT_BR;
            WAIT_BR: if (br_resolve) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            held_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

`ifdef LC3B_ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall_clr)
            stall_cnt_q <= '0;
        else if (held_q && !id_valid)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lc3b_issue_ctrl.sv
// tb/tb_lc3b_issue_ctrl.sv - directed self-checking bench for lc3b_issue_ctrl
module tb_lc3b_issue_ctrl;

    localparam logic [15:0] ADD_R1_R2_R3 = 16'h1283;
    localparam logic [15:0] ADD_R4_R1_I1 = 16'h1861;
    localparam logic [15:0] ADD_R5_R2_R3 = 16'h1A83;
    localparam logic [15:0] BRZ          = 16'h0405;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic        wb_cc;
    logic        br_resolve;
    logic        br_taken;
`ifdef LC3B_ISSUE_STALL_CNT_EN
    logic        stall_clr;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3b_issue_ctrl #(.MAX_INFLIGHT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .wb_cc      (wb_cc),
        .br_resolve (br_resolve),
`ifdef LC3B_ISSUE_STALL_CNT_EN
        .br_taken   (br_taken),
        .stall_clr  (stall_clr),
        .stall_cnt  (stall_cnt)
`else
        .br_taken   (br_taken)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [15:0] instr, input logic [15:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic wb(input logic [2:0] dest, input logic cc);
        wb_valid = 1'b1;
        wb_dest  = dest;
        wb_cc    = cc;
        tick();
        wb_valid = 1'b0;
        wb_cc    = 1'b0;
    endtask

    // Accept a BRz, issue it, and leave a second word held in WAIT_BR.
    task automatic branch_setup(input logic [15:0] pc);
        offer(BRZ, pc);
        tick();
        settle();
        check("br_issue_valid", 32'(id_valid), 32'd1);
        offer(ADD_R1_R2_R3, pc + 16'd2);
        tick();
        if_valid = 1'b0;
        settle();
        check("br_wait_valid", 32'(id_valid), 32'd0);
        check("br_wait_instr", 32'(id_instr), 32'(ADD_R1_R2_R3));
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b1; if_instr = ADD_R1_R2_R3; if_pc = 16'h1234;
        id_ready = 1'b1; wb_valid = 1'b0; wb_dest = 3'd0; wb_cc = 1'b0;
        br_resolve = 1'b0; br_taken = 1'b0;
`ifdef LC3B_ISSUE_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        // reset with fetch offering
        tick(); tick();
        settle();
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_id_instr", 32'(id_instr), 32'd0);
        check("rst_id_pc",    32'(id_pc),    32'd0);
`ifdef LC3B_ISSUE_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1; if_valid = 1'b0;

        // RAW on R1
        offer(ADD_R1_R2_R3, 16'h3000);
        settle();
        check("raw_accept_ready", 32'(if_ready), 32'd1);
        tick();
        offer(ADD_R4_R1_I1, 16'h3002);
        settle();
        check("raw_first_valid", 32'(id_valid), 32'd1);
        check("raw_first_pc",    32'(id_pc),    32'h3000);
        tick();
        if_valid = 1'b0;
        settle();
        check("raw_stall",       32'(id_valid), 32'd0);
        check("raw_held_instr",  32'(id_instr), 32'(ADD_R4_R1_I1));
        check("raw_full_ready",  32'(if_ready), 32'd0);
        wb(3'd1, 1'b1);
        settle();
        check("raw_release", 32'(id_valid), 32'd1);
        tick();
        settle();
        check("raw_empty_ready", 32'(if_ready), 32'd1);
        wb(3'd4, 1'b1);

        // issue and writeback on R1 in the same cycle
        offer(ADD_R1_R2_R3, 16'h3010);
        tick();
        offer(ADD_R1_R2_R3, 16'h3012);
        settle();
        check("sim_v1", 32'(id_valid), 32'd1);
        tick();
        offer(ADD_R4_R1_I1, 16'h3014);
        wb_valid = 1'b1; wb_dest = 3'd1; wb_cc = 1'b1;
        settle();
        check("sim_v2", 32'(id_valid), 32'd1);
        tick();
        wb_valid = 1'b0; wb_cc = 1'b0; if_valid = 1'b0;
        settle();
        check("sim_hold", 32'(id_valid), 32'd0);
        tick();
        settle();
        check("sim_hold2", 32'(id_valid), 32'd0);
        wb(3'd1, 1'b1);
        settle();
        check("sim_release", 32'(id_valid), 32'd1);
        tick();
        wb(3'd4, 1'b1);

        // saturation on R5
        offer(ADD_R5_R2_R3, 16'h3020);
        tick();
        for (int i = 0; i < 3; i++) begin
            if_pc = 16'h3022 + 16'(2 * i);
            settle();
            check("sat_issue", 32'(id_valid), 32'd1);
            tick();
        end
        if_valid = 1'b0;
        settle();
        check("sat_full_valid", 32'(id_valid), 32'd0);
        check("sat_full_ready", 32'(if_ready), 32'd0);
        tick();
        settle();
        check("sat_full_valid2", 32'(id_valid), 32'd0);
        wb(3'd5, 1'b1);
        settle();
        check("sat_release", 32'(id_valid), 32'd1);
        check("sat_release_pc", 32'(id_pc), 32'h3026);
        tick();
        for (int i = 0; i < 3; i++) wb(3'd5, 1'b1);
        settle();
        check("sat_drained_ready", 32'(if_ready), 32'd1);

        // taken branch discards the held word
        branch_setup(16'h3100);
        tick();
        settle();
        check("br_wait_valid2", 32'(id_valid), 32'd0);
        br_resolve = 1'b1; br_taken = 1'b1;
        tick();
        br_resolve = 1'b0; br_taken = 1'b0;
        settle();
        check("br_taken_ready", 32'(if_ready), 32'd1);
        check("br_taken_valid", 32'(id_valid), 32'd0);

        // not-taken branch releases the held word next cycle
        branch_setup(16'h3110);
        br_resolve = 1'b1; br_taken = 1'b0;
        settle();
        check("br_nt_same_cycle", 32'(id_valid), 32'd0);
        tick();
        br_resolve = 1'b0;
        settle();
        check("br_nt_issue", 32'(id_valid), 32'd1);
        check("br_nt_pc",    32'(id_pc),    32'h3112);
        tick();
        wb(3'd1, 1'b1);

        // taken resolve together with a redirected fetch word
        branch_setup(16'h3120);
        br_resolve = 1'b1; br_taken = 1'b1;
        offer(ADD_R5_R2_R3, 16'h4000);
        settle();
        check("br_redir_ready", 32'(if_ready), 32'd1);
        tick();
        br_resolve = 1'b0; br_taken = 1'b0; if_valid = 1'b0;
        settle();
        check("br_redir_valid", 32'(id_valid), 32'd1);
        check("br_redir_pc",    32'(id_pc),    32'h4000);
        tick();
        wb(3'd5, 1'b1);

        // reset while waiting on a branch
        branch_setup(16'h3130);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("rst_wait_ready", 32'(if_ready), 32'd1);
        check("rst_wait_valid", 32'(id_valid), 32'd0);
        offer(ADD_R1_R2_R3, 16'h3140);
        tick();
        if_valid = 1'b0;
        settle();
        check("rst_wait_run", 32'(id_valid), 32'd1);
        tick();
        wb(3'd1, 1'b1);

        // backpressure, with a stray resolve in RUN that must be ignored
        offer(ADD_R1_R2_R3, 16'h5000);
        tick();
        id_ready = 1'b0;
        offer(ADD_R5_R2_R3, 16'h5002);
        br_resolve = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_valid", 32'(id_valid), 32'd1);
            check("bp_instr", 32'(id_instr), 32'(ADD_R1_R2_R3));
            check("bp_pc",    32'(id_pc),    32'h5000);
            check("bp_ready", 32'(if_ready), 32'd0);
            tick();
            br_resolve = 1'b0; br_taken = 1'b0;
        end
        id_ready = 1'b1; if_valid = 1'b0;
        settle();
        check("bp_release", 32'(id_valid), 32'd1);
        tick();
        offer(ADD_R4_R1_I1, 16'h5004);
        tick();
        if_valid = 1'b0;
        settle();
        check("bp_reader_stall", 32'(id_valid), 32'd0);
        wb(3'd1, 1'b1);
        settle();
        check("bp_reader_release", 32'(id_valid), 32'd1);
        tick();
        wb(3'd4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_issue_ctrl.md
Name: lc3b_issue_ctrl

Overview:
- Issue-stage controller for the pipelined LC-3b core. Sits between fetch and the register-read/execute datapath.
- Holds one fetched instruction and checks it against a register/condition-code scoreboard. Releases it downstream only when hazard-free.
- Serialises control flow: no issue past an unresolved branch/jump.

Parameters:
- MAX_INFLIGHT, 3, max outstanding writes per register or CC; counter width is clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_valid  in  1  fetch offers instruction
- if_ready  out  1  controller can accept
- if_instr  in  16  instruction word
- if_pc  in  16  PC of instruction
- id_valid  out  1  issuing instruction this cycle
- id_ready  in  1  datapath accepts
- id_instr  out  16  held instruction
- id_pc  out  16  held PC
- wb_valid  in  1  register writeback retiring
- wb_dest  in  3  register being written
- wb_cc  in  1  retiring op also wrote CC
- br_resolve  in  1  one-cycle pulse, control-flow op resolved
- br_taken  in  1  qualifies br_resolve; redirect occurred

Behaviour:
- Reset (rst_n low at clk edge):
  - Holding register invalid; all scoreboard counters 0; FSM to RUN.
  - id_valid=0; if_ready=1; id_instr=0; id_pc=0.
  - Reset mid-wait discards held instruction and pending branch.
- Holding register:
  - One entry, loaded on if_valid && if_ready.
  - if_ready = !held || issue_fire, where issue_fire = id_valid && id_ready.
  - Earliest issue is the cycle after acceptance.
- Source decode by opcode:
  - ADD/AND/XOR (0001/0101/1001): [8:6], plus [2:0] when bit5=0.
  - LDR/LDB/LDI (0110/0010/1010), SHF (1101), JMP/JSRR: [8:6].
  - STR/STB/STI (0111/0011/1011): [8:6] and [11:9].
  - BR (0000): reads CC only when [11:9]!=0.
- Destination decode:
  - ADD/AND/XOR/LDR/LDB/LDI/LEA/SHF: [11:9].
  - JSR/JSRR/TRAP: R7.
  - CC written by ADD/AND/XOR/LDR/LDB/LDI/SHF.
- id_valid = held && state==RUN && every source counter==0 && (no CC read || CC counter==0) && dest counter<MAX_INFLIGHT && (no CC write || CC counter<MAX_INFLIGHT).
- Counters:
  - Dest (and CC) counter increments on issue_fire.
  - Decrements on wb_valid for wb_dest (CC on wb_valid && wb_cc).
  - Issue and writeback on the same counter in the same cycle: counter unchanged.
  - Writeback to a zero counter is an error: counter stays 0; assertion fires in simulation.
- FSM:
  - RUN: issuing BR/JMP/JSR/JSRR/TRAP/RTI (1000) moves to WAIT_BR.
  - WAIT_BR: id_valid=0; fetch may still fill the holding register.
  - WAIT_BR, on br_resolve: go to RUN. If br_taken, invalidate the held instruction the same edge; if_ready=1 the next cycle.
  - br_resolve outside WAIT_BR is ignored.
  - br_resolve and if_valid in the same cycle with br_taken: the new word is accepted (fetch already redirected); the old held word is dropped.
- id_instr/id_pc are stable while id_valid && !id_ready.

Optional Feature:
- Macro LC3B_ISSUE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits, reset 0).
  - Increments each cycle that held && !id_valid; wraps at 2^32.
  - Adds input stall_clr, which zeroes the counter with priority over increment.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- lc3b_types package:
  - opcode enum constants (op_br, op_add, ... op_trap), if not already present.
  - ctrl_state_t enum {RUN, WAIT_BR}.
- Sub-module lc3b_scoreboard:
  - 8 register counters plus 1 CC counter.
  - Inputs: increment/decrement strobes, indexes.
  - Outputs: busy/full flags per queried index.

Test Plan:
- Reset: rst_n=0 for 2 cycles with if_valid=1 -> id_valid=0, if_ready=1, all counters 0 after release.
- RAW:
  - Issue ADD R1,R2,R3 (0x1283), then ADD R4,R1,#1 (0x1861) -> second held, id_valid=0.
  - wb_valid=1, wb_dest=1, wb_cc=1 -> id_valid=1 the next cycle.
- Simultaneous issue/wb: R1 counter=1; issue ADD R1 while wb_dest=1 -> counter remains 1.
- Saturation: MAX_INFLIGHT=3, three ADD R5 issued with no wb -> fourth ADD R5 stalls; one wb on R5 releases it.
- Branch:
  - Issue BRz (0x0405) -> WAIT_BR; next word held, id_valid=0.
  - br_resolve=1, br_taken=1 -> held word discarded.
  - Repeat with br_taken=0 -> held word issues the cycle after resolve.
- Backpressure: id_ready=0 for 4 cycles with a hazard-free instruction -> id_valid=1, id_instr/id_pc constant, if_ready=0, no counter change.
